// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor colour output stage.
package compositor_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int unsigned CHAN_W = 4;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned R_LSB  = 8;
  localparam int unsigned G_LSB  = 4;
  localparam int unsigned B_LSB  = 0;

  localparam logic [11:0] DEFAULT_KEY_RGB   = 12'hF0F;
  localparam logic        DEFAULT_SYNC_IDLE = 1'b1;

  // Indexed by {y0, x0}: (0,0)=0, (1,0)=2, (0,1)=3, (1,1)=1
  localparam logic [7:0] BAYER_TABLE = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [1:0] bayer_value(input logic x0, input logic y0);
    logic [2:0] idx;
    idx = {y0, x0, 1'b0};
    return BAYER_TABLE[idx +: 2];
  endfunction

endpackage

// File: rtl/channel_reduce.sv
// Reduces one 4-bit colour channel to OUT_BITS; COMPOSITOR_DITHER_EN adds 2x2 ordered dither.
module channel_reduce
  import compositor_pkg::*;
#(
  parameter int unsigned OUT_BITS = 3
) (
  input  logic [CHAN_W-1:0]   chan,
`ifdef COMPOSITOR_DITHER_EN
  input  logic                x0,
  input  logic                y0,
`endif
  output logic [OUT_BITS-1:0] reduced
);

`ifdef COMPOSITOR_DITHER_EN
  localparam int unsigned DitherShift = CHAN_W - OUT_BITS;

  logic [1:0] bayer;
  logic [4:0] add;
  logic [4:0] sum;
  logic [3:0] sat;

  assign bayer   = bayer_value(x0, y0);
  assign add     = 5'((32'(bayer) << DitherShift) >> 2);
  assign sum     = {1'b0, chan} + add;
  assign sat     = sum[4] ? 4'hF : sum[3:0];
  assign reduced = sat[CHAN_W-1 -: OUT_BITS];
`else
  logic unused_low;

  assign unused_low = ^chan;
  assign reduced    = chan[CHAN_W-1 -: OUT_BITS];
`endif

endmodule

// File: rtl/layer_compositor.sv
// Priority/transparency/blink layer merge with 2-stage registered VGA colour and sync output.
// Optional build macro COMPOSITOR_DITHER_EN enables ordered dither in channel reduction.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int unsigned           NUM_LAYERS   = 4,
  parameter int unsigned           OUT_BITS     = 3,
  parameter logic [11:0]           KEY_RGB      = DEFAULT_KEY_RGB,
  parameter logic [NUM_LAYERS-1:0] BLINK_MASK   = '0,
  parameter int unsigned           BLINK_FRAMES = 30,
  parameter logic                  SYNC_IDLE    = DEFAULT_SYNC_IDLE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_active,
  input  logic                     in_hsync,
  input  logic                     in_vsync,
  input  logic [10:0]              in_pixel_x,
  input  logic [9:0]               in_pixel_y,
  input  logic [NUM_LAYERS-1:0]    layer_valid,
  input  logic [12*NUM_LAYERS-1:0] layer_rgb,
  input  logic [11:0]              bg_rgb,
  output logic [OUT_BITS-1:0]      VGA_R,
  output logic [OUT_BITS-1:0]      VGA_G,
  output logic [OUT_BITS-1:0]      VGA_B,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     blink_phase
);

  localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_q, blink_d;
  logic            vsync_prev_q;
  logic            vsync_edge;

  assign vsync_edge  = (vsync_prev_q == SYNC_IDLE) && (in_vsync != SYNC_IDLE);
  assign blink_phase = blink_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (vsync_edge) begin
      if (frame_cnt_q == CntW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      blink_q      <= 1'b0;
      vsync_prev_q <= SYNC_IDLE;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      blink_q      <= blink_d;
      vsync_prev_q <= in_vsync;
    end
  end

  // Scan from lowest priority upward so the lowest eligible index wins.
  rgb444_t winner;

  always_comb begin
    winner = bg_rgb;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (layer_valid[i] && (layer_rgb[12*i +: 12] != KEY_RGB) &&
          !(BLINK_MASK[i] && blink_q)) begin
        winner = layer_rgb[12*i +: 12];
      end
    end
  end

  rgb444_t col_q;
  logic    active_q;
  logic    hs1_q, vs1_q;
  logic    unused_pix;

`ifdef COMPOSITOR_DITHER_EN
  logic x0_q, y0_q;

  assign unused_pix = ^{in_pixel_x[10:1], in_pixel_y[9:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q <= 1'b0;
      y0_q <= 1'b0;
    end else begin
      x0_q <= in_pixel_x[0];
      y0_q <= in_pixel_y[0];
    end
  end
`else
  assign unused_pix = ^{in_pixel_x, in_pixel_y};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      active_q <= 1'b0;
      hs1_q    <= SYNC_IDLE;
      vs1_q    <= SYNC_IDLE;
    end else begin
      col_q    <= winner;
      active_q <= in_active;
      hs1_q    <= in_hsync;
      vs1_q    <= in_vsync;
    end
  end

  logic [OUT_BITS-1:0] r_red, g_red, b_red;

  channel_reduce #(.OUT_BITS(OUT_BITS)) u_reduce_r (
    .chan    (col_q.r),
`ifdef COMPOSITOR_DITHER_EN
    .x0      (x0_q),
    .y0      (y0_q),
`endif
    .reduced (r_red)
  );

  channel_reduce #(.OUT_BITS(OUT_BITS)) u_reduce_g (
    .chan    (col_q.g),
`ifdef COMPOSITOR_DITHER_EN
    .x0      (x0_q),
    .y0      (y0_q),
`endif
    .reduced (g_red)
  );

  channel_reduce #(.OUT_BITS(OUT_BITS)) u_reduce_b (
    .chan    (col_q.b),
`ifdef COMPOSITOR_DITHER_EN
    .x0      (x0_q),
    .y0      (y0_q),
`endif
    .reduced (b_red)
  );

  // Blanking is applied after reduction so dither can never leak colour into blank.
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
    end else begin
      VGA_R <= active_q ? r_red : '0;
      VGA_G <= active_q ? g_red : '0;
      VGA_B <= active_q ? b_red : '0;
      hsync <= hs1_q;
      vsync <= vs1_q;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: random and directed pixels against a behavioural model.
module tb_layer_compositor;

  localparam int unsigned NL = 4;
  localparam int unsigned OB = 3;
  localparam int unsigned BF = 2;
  localparam logic [3:0]  BM = 4'b0001;
  localparam logic [11:0] KEY = 12'hF0F;
  localparam logic        SI = 1'b1;
`ifdef COMPOSITOR_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_active, in_hsync, in_vsync;
  logic [10:0]   in_pixel_x;
  logic [9:0]    in_pixel_y;
  logic [NL-1:0] layer_valid;
  logic [47:0]   layer_rgb;
  logic [11:0]   bg_rgb;
  logic [OB-1:0] vga_r, vga_g, vga_b;
  logic          hsync, vsync, blink_phase;

  always #5 clk = ~clk;

  layer_compositor #(
    .NUM_LAYERS   (NL),
    .OUT_BITS     (OB),
    .KEY_RGB      (KEY),
    .BLINK_MASK   (BM),
    .BLINK_FRAMES (BF),
    .SYNC_IDLE    (SI)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_active   (in_active),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .in_pixel_x  (in_pixel_x),
    .in_pixel_y  (in_pixel_y),
    .layer_valid (layer_valid),
    .layer_rgb   (layer_rgb),
    .bg_rgb      (bg_rgb),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .hsync       (hsync),
    .vsync       (vsync),
    .blink_phase (blink_phase)
  );

  typedef struct {
    int unsigned due;
    int          r, g, b;
    logic        hs, vs;
  } exp_t;

  typedef struct {
    int unsigned due;
    logic        ph;
  } bexp_t;

  exp_t  q[$];
  bexp_t bq[$];
  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;
  int edges = 0;
  logic prev_vs = SI;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int reduce_ch(input int ch, input logic x0, input logic y0);
    int d, bay, s;
    d = 4 - int'(OB);
    if (!x0 && !y0)     bay = 0;
    else if (x0 && !y0) bay = 2;
    else if (!x0 && y0) bay = 3;
    else                bay = 1;
    s = DITHER ? ch + (bay * (1 << d)) / 4 : ch;
    if (s > 15) s = 15;
    return s >> d;
  endfunction

  function automatic exp_t idle_item(input int unsigned due);
    exp_t e;
    e.due = due; e.r = 0; e.g = 0; e.b = 0; e.hs = SI; e.vs = SI;
    return e;
  endfunction

  task automatic drive(input logic rst, input logic act, input logic hs, input logic vs,
                       input logic [3:0] val, input logic [47:0] rgb, input logic [11:0] bg,
                       input logic [10:0] x, input logic [9:0] y);
    int unsigned k;
    int w;
    bit found, phase;
    exp_t e;
    bexp_t be;
    reset = rst; in_active = act; in_hsync = hs; in_vsync = vs;
    layer_valid = val; layer_rgb = rgb; bg_rgb = bg; in_pixel_x = x; in_pixel_y = y;
    k = cyc;
    if (rst) begin
      edges = 0;
      prev_vs = SI;
      if (q.size() > 0 && q[$].due == k + 1) q[$] = idle_item(k + 1);
      else q.push_back(idle_item(k + 1));
      q.push_back(idle_item(k + 2));
      be.due = k + 1; be.ph = 1'b0;
      if (bq.size() > 0 && bq[$].due == k + 1) bq[$] = be;
      else bq.push_back(be);
    end else begin
      phase = ((edges / int'(BF)) % 2) == 1;
      w = int'(bg);
      found = 1'b0;
      for (int i = 0; i < int'(NL); i++) begin
        if (!found && val[i] && rgb[12*i +: 12] != KEY && !(BM[i] && phase)) begin
          w = int'(rgb[12*i +: 12]);
          found = 1'b1;
        end
      end
      e.due = k + 2; e.hs = hs; e.vs = vs;
      e.r = act ? reduce_ch((w >> 8) & 15, x[0], y[0]) : 0;
      e.g = act ? reduce_ch((w >> 4) & 15, x[0], y[0]) : 0;
      e.b = act ? reduce_ch(w & 15, x[0], y[0]) : 0;
      q.push_back(e);
      if (prev_vs == SI && vs != SI) edges++;
      prev_vs = vs;
      be.due = k + 1; be.ph = ((edges / int'(BF)) % 2) == 1;
      bq.push_back(be);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bexp_t be;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (vga_r !== OB'(e.r) || vga_g !== OB'(e.g) || vga_b !== OB'(e.b)) begin
        errors++;
        $display("FAIL colour cyc=%0d got R=%0d G=%0d B=%0d want R=%0d G=%0d B=%0d",
                 cyc, vga_r, vga_g, vga_b, e.r, e.g, e.b);
      end
      checks++;
      if (hsync !== e.hs || vsync !== e.vs) begin
        errors++;
        $display("FAIL sync cyc=%0d got hs=%0b vs=%0b want hs=%0b vs=%0b",
                 cyc, hsync, vsync, e.hs, e.vs);
      end
    end
    while (bq.size() > 0 && bq[0].due <= cyc) begin
      be = bq.pop_front();
      checks++;
      if (blink_phase !== be.ph) begin
        errors++;
        $display("FAIL blink_phase cyc=%0d got %0b want %0b", cyc, blink_phase, be.ph);
      end
    end
  end

  initial begin
    logic        vs_r, hs_r;
    logic [47:0] rgb;
    logic [3:0]  val;
    logic [11:0] lc;

    repeat (3) drive(1, 0, SI, SI, 4'h0, 48'h0, 12'h0, 11'd0, 10'd0);

    // Directed: priority, transparency fall-through, background, blanking.
    drive(0, 1, 0, SI, 4'b0011, {24'h0, 12'h0F0, 12'hF00}, 12'h000, 11'd0, 10'd0);
    drive(0, 1, 1, SI, 4'b0011, {24'h0, 12'h00F, KEY},     12'h000, 11'd1, 10'd0);
    drive(0, 1, 0, SI, 4'b0000, {24'h0, 12'h00F, 12'hFFF}, 12'h888, 11'd2, 10'd0);
    drive(0, 0, 1, SI, 4'b0001, {36'h0, 12'hFFF},          12'h888, 11'd3, 10'd0);
    drive(0, 1, 0, 0,  4'b0001, {36'h0, 12'hB00},          12'h000, 11'd0, 10'd0);
    drive(0, 1, 1, 0,  4'b0001, {36'h0, 12'hB00},          12'h000, 11'd1, 10'd0);
    drive(0, 1, 0, SI, 4'b0001, {36'h0, 12'hB00},          12'h000, 11'd0, 10'd1);
    drive(0, 1, 1, SI, 4'b0001, {36'h0, 12'hB00},          12'h000, 11'd1, 10'd1);
    for (int i = 0; i < 4; i++)
      drive(0, 1, SI, SI, 4'b0001, {36'h0, 12'hF00}, 12'h000, 11'(i & 1), 10'(i >> 1));

    // Blink: white layer 0 over green layer 1 across several frames.
    for (int f = 0; f < 7; f++) begin
      for (int c = 0; c < 8; c++)
        drive(0, 1, SI, (c < 3) ? ~SI : SI, 4'b0011, {24'h0, 12'h0F0, 12'hFFF}, 12'h000,
              11'(c), 10'(f));
    end

    // Reset mid-line, then resume.
    drive(1, 1, 0, ~SI, 4'b0011, {24'h0, 12'h0F0, 12'hFFF}, 12'h000, 11'd5, 10'd5);
    for (int c = 0; c < 4; c++)
      drive(0, 1, c[0], SI, 4'b0011, {24'h0, 12'h0F0, 12'hFFF}, 12'h000, 11'(c), 10'd5);

    vs_r = SI;
    hs_r = SI;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) vs_r = ~vs_r;
      if ($urandom_range(0, 3) == 0) hs_r = ~hs_r;
      val = 4'($urandom);
      for (int i = 0; i < int'(NL); i++) begin
        lc = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
        rgb[12*i +: 12] = lc;
      end
      drive((n == 1000 || n == 2000 || n == 2001), ($urandom_range(0, 7) != 0), hs_r, vs_r,
            val, rgb, 12'($urandom), 11'(n), 10'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0 || bq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size() + bq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
